writeback_stage: RTL

MEM/WB pipeline register plus write-port arbiter. It sits directly upstream of the register file and drives that file's write data, destination and write-enable.
- Aligns and extends load data.
- Merges results from the pipeline and from the long-latency multiply/divide unit onto the single register-file write port.
- Prevents starvation of the multiply/divide unit.
- Exports the registered write for forwarding.

---
 rtl/writeback_stage_pkg.sv | 17 +
 rtl/writeback_stage_load_align.sv | 43 ++++
 rtl/writeback_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the MEM/WB writeback stage: load sizes, arbiter states
// and the hardwired-zero register number.
package writeback_stage_pkg;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WAIT  = 2'd1,
        WB_FORCE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Big-endian load extraction: picks the addressed half/byte, right-justifies
// it, sign- or zero-extends it, and flags misaligned accesses.
import writeback_stage_pkg::*;

module load_align (
    input  logic [0:31] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [0:31] result,
    output logic        misalign
);

    logic [0:15] half_sel;
    logic [0:7]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? data[16:31] : data[0:15];
        case (addr_lo)
            2'd0:    byte_sel = data[0:7];
            2'd1:    byte_sel = data[8:15];
            2'd2:    byte_sel = data[16:23];
            default: byte_sel = data[24:31];
        endcase

        result   = data;
        misalign = 1'b0;
        case (size)
            LS_HALF: begin
                misalign = addr_lo[0];
                result   = {{16{sign_ext & half_sel[0]}}, half_sel};
            end
            LS_BYTE: begin
                result = {{24{sign_ext & byte_sel[0]}}, byte_sel};
            end
            // reserved size encoding behaves as a word load
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with a single register-file write port shared
// between the pipeline and the multiply/divide unit, plus anti-starvation.
import writeback_stage_pkg::*;

module writeback_stage #(
    parameter int unsigned WAIT_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_mem_to_reg,
    input  logic [4:0]  mem_dest,
    input  logic [0:31] mem_alu_result,
    input  logic [0:31] mem_load_data,
    input  logic [1:0]  mem_addr_lo,
    input  logic [1:0]  mem_load_size,
    input  logic        mem_load_signed,
    input  logic        flush,
    output logic        stall_mem,
    input  logic        md_valid,
    input  logic [4:0]  md_dest,
    input  logic [0:31] md_data,
    output logic        md_ready,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [0:31] wb_data,
    output logic        wb_misalign
);

    localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

    wb_state_e   state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        pending;
    logic [0:31] load_val;
    logic        load_misalign;

    load_align u_load_align (
        .data     (mem_load_data),
        .addr_lo  (mem_addr_lo),
        .size     (mem_load_size),
        .sign_ext (mem_load_signed),
        .result   (load_val),
        .misalign (load_misalign)
    );

    assign pending = mem_valid & mem_reg_write & ~flush;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        md_ready     = 1'b0;
        stall_mem    = 1'b0;
        case (state)
            WB_IDLE, WB_WAIT: begin
                md_ready = md_valid & ~pending;
                if (!md_valid || md_ready) begin
                    state_nxt    = WB_IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                    state_nxt    = (wait_cnt_nxt == LIMIT) ? WB_FORCE : WB_WAIT;
                end
            end
            WB_FORCE: begin
                stall_mem    = 1'b1;
                md_ready     = 1'b1;
                state_nxt    = WB_IDLE;
                wait_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = WB_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
        // the handshake outputs are combinational, so reset must mask them directly
        if (reset) begin
            md_ready  = 1'b0;
            stall_mem = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= WB_IDLE;
            wait_cnt    <= '0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            wb_misalign <= 1'b0;
            if (md_ready) begin
                wb_we   <= (md_dest != REG_ZERO);
                wb_addr <= md_dest;
                wb_data <= md_data;
            end else if (pending) begin
                if (mem_mem_to_reg && load_misalign) begin
                    wb_we       <= 1'b0;
                    wb_misalign <= 1'b1;
                end else begin
                    wb_we   <= (mem_dest != REG_ZERO);
                    wb_addr <= mem_dest;
                    wb_data <= mem_mem_to_reg ? load_val : mem_alu_result;
                end
            end else begin
                wb_we <= 1'b0;
            end
        end
    end

endmodule
